// File: rtl/mips_pkg.sv
// Shared opcode encoding for the decode and execute stages of the MIPS pipeline.
// Also holds the default datapath width and small opcode-class helpers.
package mips_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_NOR   = 4'h5;
    localparam logic [3:0] ALU_SLT   = 4'h6;
    localparam logic [3:0] ALU_SLTU  = 4'h7;
    localparam logic [3:0] ALU_SLL   = 4'h8;
    localparam logic [3:0] ALU_SRL   = 4'h9;
    localparam logic [3:0] ALU_SRA   = 4'hA;
    localparam logic [3:0] ALU_LUI   = 4'hB;
    localparam logic [3:0] ALU_MULTU = 4'hC;
    localparam logic [3:0] ALU_DIVU  = 4'hD;
    localparam logic [3:0] ALU_MFHI  = 4'hE;
    localparam logic [3:0] ALU_MFLO  = 4'hF;

    // Ops that start the iterative multiply/divide unit.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

    // Ops that must wait for a busy unit: starters and HI/LO readers.
    function automatic logic uses_hilo(input logic [3:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU) ||
               (op == ALU_MFHI)  || (op == ALU_MFLO);
    endfunction

endpackage

// File: rtl/multdiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// HI/LO are updated only on the final iteration; reads see stable values otherwise.
module multdiv #(
    parameter int WORD_SIZE = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_div,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int W     = WORD_SIZE;
    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     opb_q, opb_d;   // multiplicand or divisor
    logic [W:0]       acc_q, acc_d;   // product high half or partial remainder
    logic [W-1:0]     sh_q, sh_d;     // multiplier bits or quotient bits
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;

    logic [W:0]       step_acc;
    logic [W-1:0]     step_sh;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;

    // One iteration of whichever algorithm is in flight.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        step_acc  = acc_q;
        step_sh   = sh_q;
        mul_sum   = acc_q + (sh_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[W-1:0], sh_q[W-1]};
        if (div_q) begin
            if (div_shift >= {1'b0, opb_q}) begin
                step_acc = div_shift - {1'b0, opb_q};
                step_sh  = {sh_q[W-2:0], 1'b1};
            end else begin
                step_acc = div_shift;
                step_sh  = {sh_q[W-2:0], 1'b0};
            end
        end else begin
            step_acc = {1'b0, mul_sum[W:1]};
            step_sh  = {mul_sum[0], sh_q[W-1:1]};
        end
    end

    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        opb_d  = opb_q;
        acc_d  = acc_q;
        sh_d   = sh_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_q) begin
            acc_d = step_acc;
            sh_d  = step_sh;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                hi_d   = step_acc[W-1:0];
                lo_d   = step_sh;
            end
        end else if (start) begin
            busy_d = 1'b1;
            div_d  = op_div;
            cnt_d  = CNT_W'(MD_CYCLES);
            opb_d  = b;
            acc_d  = '0;
            sh_d   = a;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            opb_q  <= '0;
            acc_q  <= '0;
            sh_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            opb_q  <= opb_d;
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/execute.sv
// EX stage: ALU, EX/MEM pipeline registers and the HI/LO interlock toward ID.
// Multiply/divide runs in multdiv; independent ALU ops keep flowing while it is busy.
module execute #(
    parameter int WORD_SIZE = mips_pkg::WORD_SIZE,
    parameter int MD_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_id_ex,
    input  logic [3:0]           alu_op_id_ex,
    input  logic                 alu_src_id_ex,
    input  logic [WORD_SIZE-1:0] rs_data_id_ex,
    input  logic [WORD_SIZE-1:0] rt_data_id_ex,
    input  logic [WORD_SIZE-1:0] imm_id_ex,
    input  logic                 rd_en_id_ex,
    input  logic [4:0]           rd_addr_id_ex,
    input  logic                 rd_data_sel_id_ex,
    input  logic                 mem_en_id_ex,
    output logic                 stall,
    output logic [WORD_SIZE-1:0] alu_data_ex_mem,
    output logic [WORD_SIZE-1:0] rt_data_ex_mem,
    output logic                 rd_en_ex_mem,
    output logic [4:0]           rd_addr_ex_mem,
    output logic                 rd_data_sel_ex_mem,
    output logic                 mem_en_ex_mem
);

    import mips_pkg::*;

    localparam int W    = WORD_SIZE;
    localparam int SH_W = $clog2(W);

    logic [W-1:0]    op_a, op_b;
    logic [SH_W-1:0] shamt;
    logic [W-1:0]    alu_res;
    logic            accept;
    logic            md_start;
    logic            md_busy;
    logic [W-1:0]    md_hi, md_lo;

    logic [W-1:0]    alu_data_q, alu_data_d;
    logic [W-1:0]    rt_data_q, rt_data_d;
    logic            rd_en_q, rd_en_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic            rd_data_sel_q, rd_data_sel_d;
    logic            mem_en_q, mem_en_d;

    assign op_a  = rs_data_id_ex;
    assign op_b  = alu_src_id_ex ? imm_id_ex : rt_data_id_ex;
    assign shamt = op_a[SH_W-1:0];

    assign stall    = valid_id_ex & md_busy & uses_hilo(alu_op_id_ex);
    assign accept   = valid_id_ex & ~stall;
    assign md_start = accept & is_md_op(alu_op_id_ex);

    always_comb begin
        alu_res = '0;
        unique case (alu_op_id_ex)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(W-1){1'b0}}, op_a < op_b};
            ALU_SLL:  alu_res = op_b << shamt;
            ALU_SRL:  alu_res = op_b >> shamt;
            ALU_SRA:  alu_res = W'($signed(op_b) >>> shamt);
            ALU_LUI:  alu_res = {op_b[W-17:0], 16'h0000};
            ALU_MFHI: alu_res = md_hi;
            ALU_MFLO: alu_res = md_lo;
            default:  alu_res = '0;
        endcase
    end

    // Bubbles and mult/div issues must not write a GPR or memory downstream.
    always_comb begin
        alu_data_d    = alu_res;
        rt_data_d     = rt_data_id_ex;
        rd_addr_d     = rd_addr_id_ex;
        rd_data_sel_d = rd_data_sel_id_ex;
        rd_en_d       = accept & rd_en_id_ex  & ~is_md_op(alu_op_id_ex);
        mem_en_d      = accept & mem_en_id_ex & ~is_md_op(alu_op_id_ex);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_data_q    <= '0;
            rt_data_q     <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_data_sel_q <= 1'b0;
            mem_en_q      <= 1'b0;
        end else begin
            alu_data_q    <= alu_data_d;
            rt_data_q     <= rt_data_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_sel_q <= rd_data_sel_d;
            mem_en_q      <= mem_en_d;
        end
    end

    assign alu_data_ex_mem    = alu_data_q;
    assign rt_data_ex_mem     = rt_data_q;
    assign rd_en_ex_mem       = rd_en_q;
    assign rd_addr_ex_mem     = rd_addr_q;
    assign rd_data_sel_ex_mem = rd_data_sel_q;
    assign mem_en_ex_mem      = mem_en_q;

    multdiv #(
        .WORD_SIZE (W),
        .MD_CYCLES (MD_CYCLES)
    ) u_multdiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op_div (alu_op_id_ex == ALU_DIVU),
        .a      (op_a),
        .b      (op_b),
        .busy   (md_busy),
        .hi     (md_hi),
        .lo     (md_lo)
    );

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the EX stage: directed scenarios plus random traffic
// compared against an arithmetic reference model of the ALU and HI/LO unit.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  op;
    logic        src;
    logic [31:0] rs, rt, imm;
    logic        rd_en_in;
    logic [4:0]  rd_addr_in;
    logic        sel_in;
    logic        mem_en_in;

    logic        stall;
    logic [31:0] alu_data, rt_data;
    logic        rd_en, sel, mem_en;
    logic [4:0]  rd_addr;

    int total = 0;
    int bad   = 0;

    // Reference model state: HI/LO, remaining unit cycles, pending result.
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_rem = 0;
    logic        last_stall, last_acc;

    execute dut (
        .clk                (clk),
        .rst                (rst),
        .valid_id_ex        (valid),
        .alu_op_id_ex       (op),
        .alu_src_id_ex      (src),
        .rs_data_id_ex      (rs),
        .rt_data_id_ex      (rt),
        .imm_id_ex          (imm),
        .rd_en_id_ex        (rd_en_in),
        .rd_addr_id_ex      (rd_addr_in),
        .rd_data_sel_id_ex  (sel_in),
        .mem_en_id_ex       (mem_en_in),
        .stall              (stall),
        .alu_data_ex_mem    (alu_data),
        .rt_data_ex_mem     (rt_data),
        .rd_en_ex_mem       (rd_en),
        .rd_addr_ex_mem     (rd_addr),
        .rd_data_sel_ex_mem (sel),
        .mem_en_ex_mem      (mem_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        case (o)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return b << a[4:0];
            4'h9: return b >> a[4:0];
            4'hA: return 32'($signed(b) >>> a[4:0]);
            4'hB: return b * 32'h10000;
            4'hE: return m_hi;
            4'hF: return m_lo;
            default: return 32'h0;
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] t, input logic [31:0] im, input logic s,
                          input logic re, input logic [4:0] ra, input logic rs_sel,
                          input logic me);
        valid = v; op = o; rs = a; rt = t; imm = im; src = s;
        rd_en_in = re; rd_addr_in = ra; sel_in = rs_sel; mem_en_in = me;
    endtask

    // One clock: check stall, advance DUT and model, check registered outputs.
    task automatic tick();
        logic        exp_stall, acc_now, md;
        logic [31:0] b, exp_alu;
        logic [63:0] prod;
        exp_stall = valid && (m_rem > 0) && (op >= 4'hC);
        #1;
        check("stall", 32'(stall), 32'(exp_stall));
        acc_now = valid && !exp_stall;
        b       = src ? imm : rt;
        md      = (op == 4'hC) || (op == 4'hD);
        exp_alu = ref_alu(op, rs, b);
        @(posedge clk);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
        if (acc_now && md) begin
            m_rem = 32;
            if (op == 4'hC) begin
                prod = 64'(rs) * 64'(b);
                p_hi = prod[63:32];
                p_lo = prod[31:0];
            end else if (b == 0) begin
                p_hi = rs;
                p_lo = 32'hFFFF_FFFF;
            end else begin
                p_hi = rs % b;
                p_lo = rs / b;
            end
        end
        #1;
        check("rd_en", 32'(rd_en), 32'(acc_now & rd_en_in & !md));
        check("mem_en", 32'(mem_en), 32'(acc_now & mem_en_in & !md));
        if (acc_now) begin
            check("rd_addr", 32'(rd_addr), 32'(rd_addr_in));
            check("rd_sel", 32'(sel), 32'(sel_in));
            check("rt_data", rt_data, rt);
            if (!md) check("alu_data", alu_data, exp_alu);
        end
        last_stall = exp_stall;
        last_acc   = acc_now;
    endtask

    // Present inputs and hold them while stalled; returns the number of stalled cycles.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] t,
                         input logic [31:0] im, input logic s, input logic re,
                         input logic [4:0] ra, input logic me, output int stalls);
        int n = 0;
        set_in(1'b1, o, a, t, im, s, re, ra, 1'b0, me);
        do begin
            tick();
            n++;
        end while (last_stall && n < 200);
        stalls = n - 1;
        if (last_stall) begin
            total++;
            bad++;
            $error("FAIL stall_bound observed=%0d cycles expected=<200", n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        m_rem = 0; m_hi = 0; m_lo = 0;
        #1;
        check("rst_alu", alu_data, 32'h0);
        check("rst_rt", rt_data, 32'h0);
        check("rst_rd_en", 32'(rd_en), 32'h0);
        check("rst_rd_addr", 32'(rd_addr), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        int st;
        logic [3:0] ro;
        set_in(1'b0, 4'h0, 0, 0, 0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();

        // Reset in the middle of a multiply, with an MFLO waiting on it.
        issue(4'hC, 32'd9, 32'd9, 0, 1'b0, 1'b1, 5'd2, 1'b0, st);
        issue(4'h0, 32'd1, 32'd2, 0, 1'b0, 1'b1, 5'd3, 1'b0, st);
        set_in(1'b1, 4'hF, 0, 0, 0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        do_reset();
        issue(4'hF, 0, 0, 0, 1'b0, 1'b1, 5'd4, 1'b0, st);
        check("mflo_after_rst", alu_data, 32'h0);

        // ALU sweep on the sign-boundary operand.
        issue(4'h6, 32'h8000_0000, 32'd1, 0, 1'b0, 1'b1, 5'd5, 1'b0, st);
        check("slt", alu_data, 32'd1);
        issue(4'h7, 32'h8000_0000, 32'd1, 0, 1'b0, 1'b1, 5'd5, 1'b0, st);
        check("sltu", alu_data, 32'd0);
        issue(4'h1, 32'h8000_0000, 32'd1, 0, 1'b0, 1'b1, 5'd5, 1'b0, st);
        check("sub", alu_data, 32'h7FFF_FFFF);
        issue(4'hA, 32'd4, 32'h8000_0000, 0, 1'b0, 1'b1, 5'd5, 1'b0, st);
        check("sra", alu_data, 32'hF800_0000);
        issue(4'hB, 0, 0, 32'h1234, 1'b1, 1'b1, 5'd6, 1'b0, st);
        check("lui", alu_data, 32'h1234_0000);

        // MULTU then MFLO/MFHI back to back.
        issue(4'hC, 32'd7, 32'd6, 0, 1'b0, 1'b1, 5'd7, 1'b0, st);
        issue(4'hF, 0, 0, 0, 1'b0, 1'b1, 5'd8, 1'b0, st);
        check("mul1_stalls", 32'(st), 32'd32);
        check("mul1_lo", alu_data, 32'd42);
        issue(4'hE, 0, 0, 0, 1'b0, 1'b1, 5'd8, 1'b0, st);
        check("mul1_hi", alu_data, 32'd0);
        issue(4'hC, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 1'b1, 5'd7, 1'b0, st);
        issue(4'hF, 0, 0, 0, 1'b0, 1'b1, 5'd8, 1'b0, st);
        check("mul2_stalls", 32'(st), 32'd32);
        check("mul2_lo", alu_data, 32'hFFFF_FFFE);
        issue(4'hE, 0, 0, 0, 1'b0, 1'b1, 5'd8, 1'b0, st);
        check("mul2_hi", alu_data, 32'd1);

        // DIVU, including divide by zero.
        issue(4'hD, 32'd100, 32'd7, 0, 1'b0, 1'b0, 5'd0, 1'b0, st);
        issue(4'hE, 0, 0, 0, 1'b0, 1'b1, 5'd9, 1'b0, st);
        check("div_hi", alu_data, 32'd2);
        issue(4'hF, 0, 0, 0, 1'b0, 1'b1, 5'd9, 1'b0, st);
        check("div_lo", alu_data, 32'd14);
        issue(4'hD, 32'd5, 32'd0, 0, 1'b0, 1'b0, 5'd0, 1'b0, st);
        issue(4'hF, 0, 0, 0, 1'b0, 1'b1, 5'd9, 1'b0, st);
        check("div0_stalls", 32'(st), 32'd32);
        check("div0_lo", alu_data, 32'hFFFF_FFFF);
        issue(4'hE, 0, 0, 0, 1'b0, 1'b1, 5'd9, 1'b0, st);
        check("div0_hi", alu_data, 32'd5);

        // Independent work, a store and a bubble while the unit is busy; MULTU writes no GPR.
        issue(4'hC, 32'd3, 32'd5, 0, 1'b0, 1'b1, 5'd10, 1'b1, st);
        check("multu_rd_en", 32'(rd_en), 32'd0);
        issue(4'h0, 32'd10, 32'd20, 0, 1'b0, 1'b1, 5'd3, 1'b0, st);
        check("busy_add_stalls", 32'(st), 32'd0);
        check("busy_add", alu_data, 32'd30);
        check("busy_add_rd_en", 32'(rd_en), 32'd1);
        issue(4'h0, 32'hFFFF_FFFF, 32'hA5, 32'd0, 1'b1, 1'b0, 5'd0, 1'b1, st);
        check("st_addr", alu_data, 32'hFFFF_FFFF);
        check("st_data", rt_data, 32'hA5);
        check("st_mem_en", 32'(mem_en), 32'd1);
        set_in(1'b0, 4'h0, 32'd1, 32'd1, 0, 1'b0, 1'b1, 5'd11, 1'b1, 1'b1);
        tick();
        check("bubble_rd_en", 32'(rd_en), 32'd0);
        check("bubble_mem_en", 32'(mem_en), 32'd0);
        issue(4'hF, 0, 0, 0, 1'b0, 1'b1, 5'd12, 1'b0, st);
        check("busy_mul_lo", alu_data, 32'd15);

        // Random traffic against the reference model; mult/div kept less frequent.
        for (int i = 0; i < 300; i++) begin
            ro = 4'($urandom_range(0, 15));
            if ((ro == 4'hC || ro == 4'hD) && ($urandom % 3 != 0)) ro = ro - 4'hC;
            if ($urandom % 8 == 0) begin
                set_in(1'b0, ro, $urandom, $urandom, $urandom, 1'($urandom),
                       1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
                tick();
            end else begin
                set_in(1'b1, ro, $urandom, $urandom, $urandom, 1'($urandom),
                       1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
                st = 0;
                while (1) begin
                    tick();
                    st++;
                    if (!last_stall || st >= 200) break;
                end
                if (last_stall) begin
                    total++;
                    bad++;
                    $error("FAIL rand_stall_bound observed=%0d cycles expected=<200", st);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- EX stage of the 5-stage MIPS pipeline.
- Takes decoded operands and control from ID (`*_id_ex`) and computes the ALU result. Registers results and control into the EX/MEM pipeline registers (`*_ex_mem`) that feed the memory stage.
- Contains an iterative 32-cycle unsigned multiply/divide unit with HI/LO registers. Raises `stall` to ID when a HI/LO consumer or a new mult/div meets a busy unit.

Parameters:
- WORD_SIZE, 32, datapath width; only 32 is supported.
- MD_CYCLES, 32, iterations per multiply/divide; equals WORD_SIZE.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- valid_id_ex  in  1  ID presents an instruction this cycle.
- alu_op_id_ex  in  4  operation code (see Behaviour).
- alu_src_id_ex  in  1  operand B select: 1 = imm_id_ex, 0 = rt_data_id_ex.
- rs_data_id_ex  in  WORD_SIZE  operand A.
- rt_data_id_ex  in  WORD_SIZE  rt value; also the store data.
- imm_id_ex  in  WORD_SIZE  sign/zero-extended immediate, extended by ID.
- rd_en_id_ex  in  1  register write enable.
- rd_addr_id_ex  in  5  destination register.
- rd_data_sel_id_ex  in  1  WB source select; passed through unchanged.
- mem_en_id_ex  in  1  store enable.
- stall  out  1  combinational; ID must hold all `*_id_ex` inputs while it is high.
- alu_data_ex_mem  out  WORD_SIZE  result, or the memory address for loads/stores.
- rt_data_ex_mem  out  WORD_SIZE  store data.
- rd_en_ex_mem  out  1  registered register write enable.
- rd_addr_ex_mem  out  5  registered destination register.
- rd_data_sel_ex_mem  out  1  registered WB source select.
- mem_en_ex_mem  out  1  registered store enable.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; all outputs and state are cleared on the posedge where rst=1. All `*_ex_mem` outputs are 0 after reset; HI = LO = 0; busy = 0; counter = 0.
- Operands: A = rs_data_id_ex; B = alu_src_id_ex ? imm_id_ex : rt_data_id_ex.
- Opcodes:
  - 0 ADD (A+B, wrap, no overflow trap)
  - 1 SUB (A-B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOR
  - 6 SLT (signed, result 0/1)
  - 7 SLTU (unsigned, result 0/1)
  - 8 SLL (B << A[4:0])
  - 9 SRL (logical)
  - A SRA (arithmetic)
  - B LUI (B << 16)
  - C MULTU
  - D DIVU
  - E MFHI
  - F MFLO
- Latency for ALU ops (0-B, E, F when not stalled): 1 cycle. Inputs at edge N are visible on `*_ex_mem` after edge N.
- Accepted instruction: valid_id_ex=1 and stall=0. Its control fields are registered.
- Bubble: when valid_id_ex=0 or stall=1, the registered rd_en and mem_en are 0. alu_data and rt_data are don't-care but deterministic (registered as computed).
- MULTU/DIVU:
  - On accept, load operands, set busy, counter = MD_CYCLES.
  - While busy, counter decrements each edge. On the edge where counter goes 1->0, busy clears and HI/LO are written.
  - Total: HI/LO valid on the 32nd edge after the accept edge.
  - The instruction itself writes no GPR: rd_en_ex_mem and mem_en_ex_mem are forced to 0, regardless of ID.
- MULTU: {HI,LO} = A*B, unsigned 64-bit. Shift-add, one bit per cycle.
- DIVU: LO = A/B, HI = A%B, unsigned restoring division, one bit per cycle.
- DIVU with B=0: LO = 32'hFFFFFFFF, HI = A. The unit still takes MD_CYCLES cycles.
- stall = valid_id_ex & busy & (op ∈ {C, D, E, F}). Other ops proceed while the unit is busy.
- MFHI/MFLO when not busy: alu_data_ex_mem = HI/LO.
- Reset mid-operation: busy and counter clear, HI and LO return to 0, stall drops in the same cycle rst is sampled.
- Loads/stores: ADD computes the address. 32'hFFFFFFFF (GPIO) needs no special handling here.

Decomposition:
- Package `mips_pkg`: 4-bit opcode localparams (ALU_ADD…ALU_MFLO) and WORD_SIZE default. Shared with the decode stage.
- Sub-module `multdiv`: holds the iterative unit.
  - Ports: clk, rst, start, op_div, a, b, busy, hi, lo.
  - execute instantiates it and owns stall and the pipeline registers.

Test Plan:
- Reset: assert rst mid-stream -> all `*_ex_mem` = 0 and stall = 0 on the next edge. A following MFLO returns 0.
- ALU sweep:
  - A=32'h80000000, B=1: SLT gives 1, SLTU gives 0, SRA by 4 gives 32'hF8000000, SUB gives 32'h7FFFFFFF.
  - LUI with imm 32'h1234 gives 32'h12340000.
- MULTU then MFLO back-to-back, with 7*6 and 32'hFFFFFFFF*2:
  - stall is high for exactly the cycles until HI/LO are written.
  - MFLO then yields 42 and 32'hFFFFFFFE; MFHI then yields 0 and 1.
- DIVU 100/7 then MFHI/MFLO -> HI=2, LO=14.
- DIVU 5/0 -> LO=32'hFFFFFFFF, HI=5.
- Independent work during busy: ADD r3 issued while busy -> no stall, 1-cycle result. Store (mem_en=1, ADD address 32'hFFFFFFFF, rt=32'hA5) -> alu_data_ex_mem = 32'hFFFFFFFF, rt_data_ex_mem = 32'hA5, mem_en_ex_mem = 1.
- Bubble: valid_id_ex=0 with rd_en_id_ex=1 and mem_en_id_ex=1 -> rd_en_ex_mem = mem_en_ex_mem = 0.
